mont_modexp: RTL and testbench
==============================

MONT_MODEXP -- requirements
Module: mont_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 2048, meaning modulus/operand width in bits; R = 2^WIDTH.
REQ-002 SHALL have parameter EXP_WIDTH, default 2048, meaning exponent width in bits.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = single Montgomery multiply, 1 = modular exponentiation.
REQ-007 SHALL have ports x, y, n, r2, each input, WIDTH bits: multiplicand, multiplier (mode 0), modulus, R^2 mod n (mode 1).
REQ-008 SHALL have port e, input, EXP_WIDTH bits: exponent (mode 1).
REQ-009 SHALL have ports busy, done and err, each output, 1 bit: operation in progress; one-cycle completion pulse; flag set when n is even.
REQ-010 SHALL have port result, output, WIDTH bits: final value, held until the next accepted start.

Function
REQ-011 SHALL capture x, y, n, r2, e and mode into internal registers on the edge where start=1 in IDLE; later input changes have no effect.
REQ-012 SHALL ignore start while busy=1.
REQ-013 SHALL implement each Montgomery op MM(a,b) = a*b*R^-1 mod n as radix-2 bit-serial: accumulator A (WIDTH+2 bits) cleared; per cycle i = 0..WIDTH-1: A = A + a[i]*b, add n if A is odd, then A >>= 1.
REQ-014 SHALL follow the WIDTH iteration cycles with one SUB cycle: if A >= n then A = A - n; each op therefore takes exactly WIDTH+1 cycles.
REQ-015 SHALL use FSM states IDLE, CHECK, MUL, SUB, NEXT, DONE; IDLE->CHECK on accepted start; CHECK->DONE if n[0]=0, else ->MUL; MUL->SUB after WIDTH iterations; SUB->NEXT; NEXT->MUL (more ops) or ->DONE; DONE->IDLE.
REQ-016 SHALL count CHECK and NEXT as zero-cycle decision points folded into adjacent MUL/SUB cycles, so they add no latency.
REQ-017 Mode 0 SHALL perform one op, MM(x,y); result = x*y*R^-1 mod n.
REQ-018 Mode 1 SHALL perform this op sequence:
  - xm = MM(x,r2)
  - acc = MM(1,r2)
  - for each of the EXP_WIDTH exponent bits, MSB first: acc = MM(acc,acc), then acc = MM(acc,xm) if the bit is 1
  - result = MM(acc,1)
REQ-019 SHALL process all EXP_WIDTH exponent bits, leading zeros included; op count = 3 + EXP_WIDTH + popcount(e).
REQ-020 SHALL assert done, for exactly one cycle, ops*(WIDTH+1)+1 cycles after the start-sampling edge; mode 0 latency = WIDTH+2.
REQ-021 SHALL hold busy=1 from the edge after start through the cycle before done; busy=0 while done=1.
REQ-022 SHALL update result on the same edge that raises done; err is updated on every completion and held with result.
REQ-023 If n is even: err=1, result=0, done pulses 2 cycles after start, no op executed.
REQ-024 If e=0 in mode 1: result = 1 mod n (0 when n=1); ops = 3 + EXP_WIDTH.
REQ-025 Behaviour for operands >= n is unspecified except that the FSM still terminates with the stated latency.

Reset
REQ-026 On rst=1 the block SHALL immediately and asynchronously set: state IDLE, busy=0, done=0, err=0, result=0, all counters and accumulators cleared.
REQ-027 rst asserted mid-operation SHALL abort the operation with no done pulse; a start after rst deasserts is accepted normally.
REQ-028 start coincident with rst SHALL be ignored.

Verification (WIDTH=8, EXP_WIDTH=8, n=13, r2=3)
REQ-029 Mode 0, x=5, y=7 -> result=1, err=0, done exactly 10 cycles after start.
REQ-030 Mode 1, x=4, e=13 -> result=4, done exactly 127 cycles after start (14 ops).
REQ-031 Mode 1, x=4, e=0 -> result=1, done exactly 100 cycles after start (11 ops).
REQ-032 n=12, any mode -> err=1, result=0, done 2 cycles after start; next valid start clears err.
REQ-033 rst pulsed at cycle 50 of a mode 1 run -> busy=0, no done, result=0; a following mode 0 run (x=5, y=7) -> 1.
REQ-034 start re-pulsed while busy, and x changed after start -> both ignored; result matches the originally captured operands.

Source files
------------

// File: rtl/mont_modexp.sv
// Bit-serial radix-2 Montgomery multiplier with a left-to-right square-and-multiply
// sequencer for modular exponentiation. One Montgomery op takes WIDTH+1 cycles.
module mont_modexp #(
    parameter int WIDTH     = 2048,
    parameter int EXP_WIDTH = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     r2,
    input  logic [EXP_WIDTH-1:0] e,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, MUL, SUB, NEXT, DONE} state_t;
    typedef enum logic [2:0] {OP_XM, OP_ONE, OP_SQR, OP_MUL, OP_FIN} op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d, nxt_op;
    logic [AW-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, n_q, n_d, r2_q, r2_d;
    logic [WIDTH-1:0]     xm_q, xm_d, pw_q, pw_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic                 mode_q, mode_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d, nxt_bit;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     op_a, op_b, res;
    logic                 launch, finish;

    // One radix-2 Montgomery iteration: add a_i*b, make even with n, halve.
    function automatic logic [AW-1:0] mont_step(input logic [AW-1:0] acc,
                                                input logic abit,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] m);
        logic [AW-1:0] t;
        t = acc + (abit ? {2'b00, b} : AW'(0));
        if (t[0]) t = t + {2'b00, m};
        return t >> 1;
    endfunction

    function automatic logic [AW-1:0] cond_sub(input logic [AW-1:0] acc,
                                               input logic [WIDTH-1:0] m);
        return (acc >= {2'b00, m}) ? acc - {2'b00, m} : acc;
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        n_d      = n_q;
        r2_d     = r2_q;
        e_d      = e_q;
        mode_d   = mode_q;
        xm_d     = xm_q;
        pw_d     = pw_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        res      = acc_q[WIDTH-1:0];
        op_a     = '0;
        op_b     = '0;
        nxt_op   = op_q;
        nxt_bit  = bit_q;
        launch   = 1'b0;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    n_d     = n;
                    r2_d    = r2;
                    e_d     = e;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!n_q[0]) begin
                    state_d = DONE;
                end else begin
                    // first iteration of the first op runs in this cycle
                    op_a   = x_q;
                    op_b   = mode_q ? r2_q : y_q;
                    nxt_op = mode_q ? OP_XM : OP_FIN;
                    launch = 1'b1;
                end
            end
            MUL: begin
                acc_d = mont_step(acc_q, a_q[0], b_q, n_q);
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = SUB;
            end
            SUB: begin
                acc_d   = cond_sub(acc_q, n_q);
                state_d = NEXT;
            end
            NEXT: begin
                // store the finished op and launch the next one in the same cycle
                case (op_q)
                    OP_XM: begin
                        xm_d   = res;
                        op_a   = WIDTH'(1);
                        op_b   = r2_q;
                        nxt_op = OP_ONE;
                    end
                    OP_ONE: begin
                        pw_d    = res;
                        op_a    = res;
                        op_b    = res;
                        nxt_op  = OP_SQR;
                        nxt_bit = BW'(EXP_WIDTH - 1);
                    end
                    OP_SQR, OP_MUL: begin
                        pw_d = res;
                        if (op_q == OP_SQR && e_q[bit_q]) begin
                            op_a   = res;
                            op_b   = xm_q;
                            nxt_op = OP_MUL;
                        end else if (bit_q == '0) begin
                            op_a   = res;
                            op_b   = WIDTH'(1);
                            nxt_op = OP_FIN;
                        end else begin
                            op_a    = res;
                            op_b    = res;
                            nxt_op  = OP_SQR;
                            nxt_bit = bit_q - BW'(1);
                        end
                    end
                    default: finish = 1'b1;
                endcase
                bit_d = nxt_bit;
                if (finish) begin
                    result_d = res;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    launch = 1'b1;
                end
            end
            DONE: begin
                result_d = '0;
                err_d    = 1'b1;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            acc_d   = mont_step(AW'(0), op_a[0], op_b, n_q);
            a_d     = op_a >> 1;
            b_d     = op_b;
            op_d    = nxt_op;
            cnt_d   = CW'(1);
            state_d = MUL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_XM;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            r2_q     <= '0;
            e_q      <= '0;
            mode_q   <= 1'b0;
            xm_q     <= '0;
            pw_q     <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            n_q      <= n_d;
            r2_q     <= r2_d;
            e_q      <= e_d;
            mode_q   <= mode_d;
            xm_q     <= xm_d;
            pw_q     <= pw_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
endmodule

// File: tb/tb_mont_modexp.sv
// Scoreboard bench for mont_modexp at WIDTH=8, EXP_WIDTH=8: expected result, err and
// latency are queued at start and compared when done pulses.
module tb_mont_modexp;
    logic       clk = 1'b0;
    logic       rst, start, mode;
    logic [7:0] x, y, n, r2, e;
    logic       busy, done, err;
    logic [7:0] result;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] res;
        logic       er;
        int         start_cyc;
        int         lat;
    } exp_t;
    exp_t sb[$];

    mont_modexp #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x(x), .y(y), .n(n), .r2(r2), .e(e),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Montgomery product reference: x*y*R^-1 mod n with R = 256.
    function automatic int mm_ref(input int a, input int b, input int m);
        int rinv = 0;
        for (int k = 0; k < m; k++)
            if ((256 * k) % m == 1) rinv = k;
        return ((a * b) % m) * rinv % m;
    endfunction

    function automatic int pow_ref(input int a, input int ex, input int m);
        int r = 1 % m;
        for (int k = 0; k < ex; k++) r = (r * a) % m;
        return r;
    endfunction

    task automatic launch(input logic m, input int xi, input int yi, input int ni,
                          input int ei, input int exp_res, input logic exp_err, input int lat);
        exp_t t;
        @(negedge clk);
        mode  = m;
        x     = 8'(xi);
        y     = 8'(yi);
        n     = 8'(ni);
        r2    = 8'(65536 % ni);
        e     = 8'(ei);
        start = 1'b1;
        t.res = 8'(exp_res);
        t.er  = exp_err;
        t.start_cyc = cyc + 1;
        t.lat = lat;
        sb.push_back(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t t;
            check("done_expected", sb.size() != 0, 1);
            check("busy_at_done", busy, 0);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                check("result", result, t.res);
                check("err", err, t.er);
                check("latency", cyc - t.start_cyc, t.lat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int moduli[6] = '{13, 11, 97, 251, 201, 1};
        int nn, xa, ya, ea;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        x = '0; y = '0; n = '0; r2 = '0; e = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        rst = 1'b0;

        launch(1'b0, 5, 7, 13, 0, 1, 1'b0, 10);
        drain(50);
        launch(1'b1, 4, 0, 13, 13, 4, 1'b0, 127);
        drain(300);
        launch(1'b1, 4, 0, 13, 0, 1, 1'b0, 100);
        drain(300);
        launch(1'b0, 5, 7, 12, 0, 0, 1'b1, 2);
        drain(50);
        launch(1'b1, 4, 0, 12, 13, 0, 1'b1, 2);
        drain(50);
        launch(1'b0, 5, 7, 13, 0, 1, 1'b0, 10);
        drain(50);
        launch(1'b1, 0, 0, 1, 0, 0, 1'b0, 100);
        drain(300);
        launch(1'b0, 5, 7, 13, 0, 1, 1'b0, 10);
        drain(50);

        // asynchronous abort of a running exponentiation
        launch(1'b1, 4, 0, 13, 13, 4, 1'b0, 127);
        repeat (48) @(negedge clk);
        check("busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        launch(1'b0, 5, 7, 13, 0, 1, 1'b0, 10);
        drain(50);

        // start while busy and late operand change are ignored
        launch(1'b0, 5, 7, 13, 0, 1, 1'b0, 10);
        check("busy_mid", busy, 1);
        x = 8'd9; y = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(50);
        repeat (20) @(negedge clk);

        // start together with reset is ignored
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("start_in_rst", busy, 0);
        repeat (15) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            nn = moduli[i];
            xa = $urandom_range(0, nn - 1);
            ya = $urandom_range(0, nn - 1);
            launch(1'b0, xa, ya, nn, 0, mm_ref(xa, ya, nn), 1'b0, 10);
            drain(50);
        end
        for (int i = 0; i < 5; i++) begin
            nn = moduli[i];
            xa = $urandom_range(0, nn - 1);
            ea = $urandom_range(0, 255);
            launch(1'b1, xa, 0, nn, ea, pow_ref(xa, ea, nn), 1'b0,
                   (11 + $countones(8'(ea))) * 9 + 1);
            drain(400);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
